trigger_pulse_gen: RTL and testbench

Clock-domain event emitter; the transmit-side counterpart of the sticky set/reset capture flag used on trigger inputs.
- Accepts single-cycle trigger requests from the sequencer core.
- Drives an external trigger line with pulses of programmable width, separated by a programmable minimum gap.
- Queues requests that arrive while a pulse is in progress.
- Sits between the pulse-program engine and the TTL/DDS trigger outputs.

---
 rtl/trigger_pulse_gen_pkg.sv | 13 +
 rtl/trigger_pulse_gen_load_down_counter.sv | 41 ++++
 rtl/trigger_pulse_gen.sv | 158 +++++++++++++++
 tb/tb_trigger_pulse_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/trigger_pulse_gen_pkg.sv
// Shared types and defaults for the trigger pulse generator.
package trigger_pulse_gen_pkg;

  typedef enum logic [1:0] {
    TRG_IDLE = 2'd0,
    TRG_HIGH = 2'd1,
    TRG_GAP  = 2'd2
  } trgState_e;

  localparam int DEFAULT_CNT_BITS  = 16;
  localparam int DEFAULT_PEND_BITS = 4;

endpackage

// File: rtl/trigger_pulse_gen_load_down_counter.sv
// Loadable down-counter. zero_next is high when the count will be 1 after
// the coming clock edge, so the owner can register its terminal condition.
// The count stops at 1 and never wraps; an all-ones load is a legal maximum.
module load_down_counter
  import trigger_pulse_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CNT_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             dec,
  output logic             zero_next
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: a load wins over a decrement, and decrementing stops at 1.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (dec && (count_q > WIDTH'(1))) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  assign zero_next = (count_d == WIDTH'(1));

  // Count register, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/trigger_pulse_gen.sv
// Trigger pulse generator: turns single-cycle requests into pulses of
// programmable width separated by a programmable minimum gap. Requests that
// arrive while a pulse is in flight are queued in a saturating counter.
module trigger_pulse_gen
  import trigger_pulse_gen_pkg::*;
#(
  parameter int CNT_BITS  = DEFAULT_CNT_BITS,
  parameter int PEND_BITS = DEFAULT_PEND_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 trigger,
  input  logic [CNT_BITS-1:0]  pulse_width,
  input  logic [CNT_BITS-1:0]  gap_width,
  input  logic                 clear_overflow,
  output logic                 pulse_out,
  output logic                 busy,
  output logic [PEND_BITS-1:0] pending,
  output logic                 overflow,
  output logic                 done
);

  trgState_e            state_q, state_d;
  logic [PEND_BITS-1:0] pend_q, pend_d;
  logic [CNT_BITS-1:0]  gap_q, gap_d;
  logic                 ovf_q, ovf_d;
  logic                 pulse_q, pulse_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 term_q;

  logic                 startOk;
  logic                 consume;
  logic                 drop;
  logic                 cntLoad;
  logic                 cntDec;
  logic [CNT_BITS-1:0]  cntValue;
  logic                 zeroNext;
  logic [CNT_BITS-1:0]  widthClamped;
  logic [CNT_BITS-1:0]  gapClamped;

  assign widthClamped = (pulse_width == '0) ? CNT_BITS'(1) : pulse_width;
  assign gapClamped   = (gap_width == '0) ? CNT_BITS'(1) : gap_width;
  assign startOk      = enable && (trigger || (pend_q != '0));

  // One counter times both HIGH and GAP, since the two phases never overlap.
  load_down_counter #(.WIDTH(CNT_BITS)) uTimer (
    .clock     (clock),
    .reset     (reset),
    .load      (cntLoad),
    .value     (cntValue),
    .dec       (cntDec),
    .zero_next (zeroNext)
  );

  // Next-state logic: FSM transitions, counter control, queue and overflow.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    gap_d    = gap_q;
    ovf_d    = ovf_q;
    consume  = 1'b0;
    drop     = 1'b0;
    cntLoad  = 1'b0;
    cntDec   = 1'b0;
    cntValue = widthClamped;

    case (state_q)
      TRG_IDLE: begin
        if (startOk) begin
          state_d = TRG_HIGH;
          consume = 1'b1;
          cntLoad = 1'b1;
          gap_d   = gapClamped;
        end
      end
      TRG_HIGH: begin
        if (term_q) begin
          state_d  = TRG_GAP;
          cntLoad  = 1'b1;
          cntValue = gap_q;
        end else begin
          cntDec = 1'b1;
        end
      end
      TRG_GAP: begin
        if (term_q) begin
          if (startOk) begin
            state_d = TRG_HIGH;
            consume = 1'b1;
            cntLoad = 1'b1;
            gap_d   = gapClamped;
          end else begin
            state_d = TRG_IDLE;
          end
        end else begin
          cntDec = 1'b1;
        end
      end
      default: begin
        state_d = TRG_IDLE;
      end
    endcase

    if (consume) begin
      if ((pend_q != '0) && !trigger) begin
        pend_d = pend_q - PEND_BITS'(1);
      end
    end else if (trigger) begin
      if (pend_q == {PEND_BITS{1'b1}}) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_BITS'(1);
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  assign pulse_d = (state_d == TRG_HIGH);
  assign busy_d  = (state_d != TRG_IDLE);
  assign done_d  = (state_d == TRG_HIGH) && zeroNext;

  // State and registered outputs; reset truncates any pulse in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= TRG_IDLE;
      pend_q  <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      term_q  <= zeroNext;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  assign done      = done_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Self-checking bench for trigger_pulse_gen. The reference model tracks the
// start cycle of the most recent pulse with its latched width and gap, and
// derives every output from absolute cycle arithmetic.
module tb_trigger_pulse_gen;

  localparam int CW   = 4;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          trigger;
  logic          clear_overflow;
  logic [CW-1:0] pulse_width;
  logic [CW-1:0] gap_width;
  logic          pulse_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;
  logic          done;

  int total = 0;
  int bad   = 0;

  longint cyc    = 0;
  longint pStart = -100;
  int     mW     = 1;
  int     mG     = 1;
  int     mPend  = 0;
  bit     mOvf   = 1'b0;

  int doneCount;

  trigger_pulse_gen #(.CNT_BITS(CW), .PEND_BITS(PW)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .trigger        (trigger),
    .pulse_width    (pulse_width),
    .gap_width      (gap_width),
    .clear_overflow (clear_overflow),
    .pulse_out      (pulse_out),
    .busy           (busy),
    .pending        (pending),
    .overflow       (overflow),
    .done           (done)
  );

  always #5 clock = ~clock;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit canStart;
    bit drop;
    canStart = 1'b0;
    drop     = 1'b0;
    cyc++;
    if (reset) begin
      mPend  = 0;
      mOvf   = 1'b0;
      pStart = -100;
      mW     = 1;
      mG     = 1;
    end else begin
      canStart = enable && (cyc >= pStart + mW + mG) && (trigger || (mPend > 0));
      if (canStart) begin
        if ((mPend > 0) && !trigger) mPend--;
        pStart = cyc;
        mW     = (pulse_width == 0) ? 1 : int'(pulse_width);
        mG     = (gap_width == 0) ? 1 : int'(gap_width);
      end else if (trigger) begin
        if (mPend == PMAX) drop = 1'b1;
        else mPend++;
      end
      if (drop) mOvf = 1'b1;
      else if (clear_overflow) mOvf = 1'b0;
    end
  endtask

  task automatic checkOutput();
    bit eHigh;
    bit eBusy;
    bit eDone;
    eHigh = (cyc >= pStart) && (cyc < pStart + mW);
    eBusy = (cyc >= pStart) && (cyc < pStart + mW + mG);
    eDone = (cyc == pStart + mW - 1);
    checkOne("pulse_out", 32'(pulse_out), 32'(eHigh));
    checkOne("busy",      32'(busy),      32'(eBusy));
    checkOne("done",      32'(done),      32'(eDone));
    checkOne("pending",   32'(pending),   32'(mPend));
    checkOne("overflow",  32'(overflow),  32'(mOvf));
  endtask

  task automatic applyStimulus(input bit r, input bit en, input bit tr, input bit clr,
                               input int pw, input int gw);
    reset          = r;
    enable         = en;
    trigger        = tr;
    clear_overflow = clr;
    pulse_width    = CW'(pw);
    gap_width      = CW'(gw);
    modelEdge();
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOne("reset_busy", 32'(busy), 32'd0);
    checkOne("reset_pend", 32'(pending), 32'd0);

    // Single pulse W=3, G=2
    applyStimulus(0, 1, 1, 0, 3, 2);
    checkOne("t1_first_high", 32'(pulse_out), 32'd1);
    applyStimulus(0, 1, 0, 0, 3, 2);
    applyStimulus(0, 1, 0, 0, 3, 2);
    checkOne("t1_done", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 3, 2);
    checkOne("t1_idle", 32'(busy), 32'd0);

    // W=0, G=0 with triggers on two consecutive cycles
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOne("t2_pend_peak", 32'(pending), 32'd1);
    checkOne("t2_gap_low", 32'(pulse_out), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOne("t2_second_high", 32'(pulse_out), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0);

    // Queue saturation and overflow with W=10
    doneCount = 0;
    applyStimulus(0, 1, 1, 0, 10, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 1, 0, 10, 1);
      if (done === 1'b1) doneCount++;
    end
    checkOne("t3_pend_sat", 32'(pending), 32'd3);
    checkOne("t3_ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(0, 1, 0, 0, 10, 1);
      if (done === 1'b1) doneCount++;
    end
    checkOne("t3_pulse_count", 32'(doneCount), 32'd4);
    applyStimulus(0, 1, 0, 1, 10, 1);
    checkOne("t3_ovf_clear", 32'(overflow), 32'd0);

    // Triggers queued while disabled, emitted after enable returns
    applyStimulus(0, 0, 1, 0, 2, 3);
    applyStimulus(0, 0, 1, 0, 2, 3);
    applyStimulus(0, 0, 0, 0, 2, 3);
    applyStimulus(0, 0, 0, 0, 2, 3);
    checkOne("t4_pend_held", 32'(pending), 32'd2);
    checkOne("t4_no_pulse", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 2, 3);
    checkOne("t4_pend_drained", 32'(pending), 32'd0);

    // Reset in the middle of a pulse with requests queued
    applyStimulus(0, 1, 1, 0, 5, 1);
    applyStimulus(0, 1, 1, 0, 5, 1);
    applyStimulus(0, 1, 1, 0, 5, 1);
    applyStimulus(1, 1, 0, 0, 5, 1);
    checkOne("t5_pulse_cut", 32'(pulse_out), 32'd0);
    checkOne("t5_pend_cleared", 32'(pending), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 5, 1);
    checkOne("t5_stays_idle", 32'(busy), 32'd0);

    // Width change mid-pulse affects only the queued pulse
    applyStimulus(0, 1, 1, 0, 4, 2);
    applyStimulus(0, 1, 1, 0, 1, 2);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0, 1, 2);

    // All-ones width and gap are legal maxima
    applyStimulus(0, 1, 1, 0, 15, 15);
    for (int i = 0; i < 35; i++) applyStimulus(0, 1, 0, 0, 15, 15);

    // Randomized traffic against the reference model
    for (int i = 0; i < 700; i++) begin
      int pw;
      int gw;
      pw = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
      gw = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 19) == 0),
                    pw, gw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
